// File: rtl/sigdelay_multitap.sv
// sigdelay_multitap
//   Multi-tap circular-buffer delay line. Each accepted sample is written into
//   a 2^ADDRESS_WIDTH deep buffer, then NUM_TAPS delayed copies are read back
//   one per cycle through a single read port and presented as per-tap outputs
//   plus their sum.
//
//   Optional build macro SIGDELAY_MULTITAP_FEEDBACK_EN: when defined, the value
//   written is sat(in_sample + (previous mix >> (log2(NUM_TAPS)+1))), which
//   produces a decaying echo. When undefined, the raw sample is written.
//
// Ports
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   in_valid_i    sample strobe, taken when busy_o=0
//   in_sample_i   input sample (unsigned)
//   tap_offset_i  packed delays, tap i at [i*AW +: AW]
//   tap_en_i      per-tap enable
//   busy_o        high while a sample is being processed
//   out_valid_o   one-cycle pulse, tap_out_o/mix_out_o updated in that cycle
//   tap_out_o     packed tap samples, tap i at [i*DW +: DW]
//   mix_out_o     sum of enabled, valid taps
//   overrun_o     sticky: a sample arrived while busy
//
// State   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a sample
// WRITE   | sample written to buffer[wr_ptr], fill advanced
// READ    | one tap address issued per cycle, previous tap captured
// DRAIN   | last tap captured, results loaded into the output registers
// DONE    | out_valid pulse, wr_ptr advanced; may accept the next sample

module sigdelay_multitap #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 9,
    parameter int NUM_TAPS      = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid_i,
    input  logic [DATA_WIDTH-1:0]                in_sample_i,
    input  logic [NUM_TAPS*ADDRESS_WIDTH-1:0]    tap_offset_i,
    input  logic [NUM_TAPS-1:0]                  tap_en_i,
    output logic                                 busy_o,
    output logic                                 out_valid_o,
    output logic [NUM_TAPS*DATA_WIDTH-1:0]       tap_out_o,
    output logic [DATA_WIDTH+$clog2(NUM_TAPS)-1:0] mix_out_o,
    output logic                                 overrun_o
);

    localparam int DW    = DATA_WIDTH;
    localparam int AW    = ADDRESS_WIDTH;
    localparam int AW1   = AW + 1;
    localparam int MW    = DATA_WIDTH + $clog2(NUM_TAPS);
    localparam int DEPTH = 1 << AW;
    localparam int IW    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_TAPS - 1);
    localparam logic [AW:0]   FILL_MAX = {1'b1, {AW{1'b0}}};

    logic [2:0]               state_q, state_d;
    logic [AW-1:0]            wr_ptr_q;
    logic [AW:0]              fill_q;
    logic [IW-1:0]            idx_q;
    logic [DW-1:0]            smp_q;
    logic [NUM_TAPS*AW-1:0]   off_q;
    logic [NUM_TAPS-1:0]      en_q;
    logic                     overrun_q;
    logic [DW-1:0]            tap_work_q [NUM_TAPS];
    logic [MW-1:0]            mix_work_q;
    logic [DW-1:0]            tap_out_q  [NUM_TAPS];
    logic [MW-1:0]            mix_out_q;

    logic [DW-1:0]            mem [0:DEPTH-1];
    logic [DW-1:0]            rd_data_q;
    logic [AW-1:0]            rd_addr;
    logic [DW-1:0]            wr_data;
    logic                     wr_en;

    logic                     accept;
    logic                     capture;
    logic [IW-1:0]            cap_idx;
    logic [AW-1:0]            cap_off;
    logic [DW-1:0]            cap_val;

    // DONE doubles as a ready cycle so a held in_valid yields one sample
    // every NUM_TAPS+3 cycles without an extra IDLE bubble.
    assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign out_valid_o = (state_q == S_DONE);
    assign overrun_o   = overrun_q;
    assign mix_out_o   = mix_out_q;
    assign accept      = in_valid_i && !busy_o;

    for (genvar g = 0; g < NUM_TAPS; g++) begin : g_tap_out
        assign tap_out_o[g*DW +: DW] = tap_out_q[g];
    end

`ifdef SIGDELAY_MULTITAP_FEEDBACK_EN
    localparam int MW1 = MW + 1;
    localparam logic [MW:0] SAT_MAX = MW1'({DW{1'b1}});
    logic [MW-1:0] fb_q;
    logic [MW:0]   fb_sum;

    always_comb begin
        fb_sum  = MW1'(smp_q) + MW1'(fb_q >> ($clog2(NUM_TAPS) + 1));
        wr_data = (fb_sum > SAT_MAX) ? {DW{1'b1}} : fb_sum[DW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fb_q <= '0;
        end else if (state_q == S_DONE) begin
            fb_q <= mix_out_q;
        end
    end
`else
    assign wr_data = smp_q;
`endif

    assign wr_en   = (state_q == S_WRITE) && !rst;
    assign rd_addr = wr_ptr_q - off_q[idx_q*AW +: AW];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wr_data;
        end
        rd_data_q <= mem[rd_addr];
    end

    // Read data lags the issued address by one cycle, so READ idx captures
    // tap idx-1 and DRAIN captures the last tap.
    always_comb begin
        capture = ((state_q == S_READ) && (idx_q != '0)) || (state_q == S_DRAIN);
        cap_idx = (state_q == S_DRAIN) ? IDX_LAST : idx_q - IW'(1);
        cap_off = off_q[cap_idx*AW +: AW];
        cap_val = (en_q[cap_idx] && ({1'b0, cap_off} < fill_q)) ? rd_data_q : '0;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_WRITE;
            S_WRITE: state_d = S_READ;
            S_READ:  if (idx_q == IDX_LAST) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = accept ? S_WRITE : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            idx_q      <= '0;
            smp_q      <= '0;
            off_q      <= '0;
            en_q       <= '0;
            overrun_q  <= 1'b0;
            mix_work_q <= '0;
            mix_out_q  <= '0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                tap_work_q[i] <= '0;
                tap_out_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;

            if (in_valid_i && busy_o) begin
                overrun_q <= 1'b1;
            end

            if (accept) begin
                smp_q <= in_sample_i;
                off_q <= tap_offset_i;
                en_q  <= tap_en_i;
            end

            case (state_q)
                S_WRITE: begin
                    if (fill_q != FILL_MAX) fill_q <= fill_q + AW1'(1);
                    idx_q      <= '0;
                    mix_work_q <= '0;
                end
                S_READ:  idx_q    <= idx_q + IW'(1);
                S_DONE:  wr_ptr_q <= wr_ptr_q + AW'(1);
                default: ;
            endcase

            if (capture) begin
                tap_work_q[cap_idx] <= cap_val;
                mix_work_q          <= mix_work_q + MW'(cap_val);
            end

            if (state_q == S_DRAIN) begin
                for (int i = 0; i < NUM_TAPS; i++) begin
                    tap_out_q[i] <= (IW'(i) == cap_idx) ? cap_val : tap_work_q[i];
                end
                mix_out_q <= mix_work_q + MW'(cap_val);
            end
        end
    end

endmodule

// File: tb/tb_sigdelay_multitap.sv
module tb_sigdelay_multitap;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NT = 4;
    localparam int MW = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [DW-1:0]     in_sample;
    logic [NT*AW-1:0]  tap_offset;
    logic [NT-1:0]     tap_en;
    logic              busy;
    logic              out_valid;
    logic [NT*DW-1:0]  tap_out;
    logic [MW-1:0]     mix_out;
    logic              overrun;

    int n_cmp = 0;
    int n_err = 0;

    sigdelay_multitap #(
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW),
        .NUM_TAPS     (NT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_sample_i (in_sample),
        .tap_offset_i(tap_offset),
        .tap_en_i    (tap_en),
        .busy_o      (busy),
        .out_valid_o (out_valid),
        .tap_out_o   (tap_out),
        .mix_out_o   (mix_out),
        .overrun_o   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  smp;
        logic [15:0] off;
        logic [3:0]  en;
        logic [31:0] taps;
        logic [9:0]  mix;
    } vec_t;

    vec_t vecs [5];

    function automatic logic [15:0] off4(input int a, input int b, input int c, input int d);
        return {4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    function automatic logic [31:0] t4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        check({name, "_ready"}, 32'(busy), 0);
    endtask

    // Present one sample, then scramble the inputs to show they are ignored
    // after acceptance; returns once out_valid is seen (or the bound expires).
    task automatic send(input string name, input logic [7:0] s,
                        input logic [15:0] off, input logic [3:0] en);
        int n = 0;
        wait_ready(name);
        in_sample  = s;
        tap_offset = off;
        tap_en     = en;
        in_valid   = 1'b1;
        tick();
        in_valid   = 1'b0;
        in_sample  = ~s;
        tap_offset = ~off;
        tap_en     = ~en;
        check({name, "_busy_after_accept"}, 32'(busy), 1);
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({name, "_latency"}, n, 6);
    endtask

    task automatic check_out(input string name, input logic [31:0] taps, input int mix);
        for (int i = 0; i < NT; i++) begin
            check($sformatf("%s_tap%0d", name, i), 32'(tap_out[i*DW +: DW]), 32'(taps[i*8 +: 8]));
        end
        check({name, "_mix"}, 32'(mix_out), mix);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_sample  = '0;
        tap_offset = '0;
        tap_en     = '0;

`ifdef SIGDELAY_MULTITAP_FEEDBACK_EN
        vecs[0] = '{8'h80, off4(0, 1, 2, 3),  4'b1111, t4(128, 0, 0, 0),   10'd128};
        vecs[1] = '{8'd9,  off4(0, 0, 0, 0),  4'b0101, t4(25, 0, 25, 0),   10'd50};
        vecs[2] = '{8'd7,  off4(0, 1, 2, 3),  4'b1111, t4(13, 25, 128, 0), 10'd166};
        vecs[3] = '{8'hFF, off4(3, 2, 1, 0),  4'b1111, t4(128, 25, 13, 255), 10'd421};
        vecs[4] = '{8'd0,  off4(1, 1, 15, 4), 4'b1010, t4(0, 255, 0, 128), 10'd383};
`else
        vecs[0] = '{8'h80, off4(0, 1, 2, 3),  4'b1111, t4(128, 0, 0, 0),   10'd128};
        vecs[1] = '{8'd9,  off4(0, 0, 0, 0),  4'b0101, t4(9, 0, 9, 0),     10'd18};
        vecs[2] = '{8'd7,  off4(0, 1, 2, 3),  4'b1111, t4(7, 9, 128, 0),   10'd144};
        vecs[3] = '{8'hFF, off4(3, 2, 1, 0),  4'b1111, t4(128, 9, 7, 255), 10'd399};
        vecs[4] = '{8'd0,  off4(1, 1, 15, 4), 4'b1010, t4(0, 255, 0, 128), 10'd383};
`endif

        tick();
        tick();
        rst = 1'b0;
        check("rst_busy",      32'(busy), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_tap_out",   32'(tap_out), 0);
        check("rst_mix",       32'(mix_out), 0);
        check("rst_overrun",   32'(overrun), 0);

`ifdef SIGDELAY_MULTITAP_FEEDBACK_EN
        send("fb1", 8'd100, off4(0, 0, 0, 0), 4'hF);
        check_out("fb1", t4(100, 100, 100, 100), 400);
        send("fb2", 8'd100, off4(0, 0, 0, 0), 4'hF);
        check_out("fb2", t4(150, 150, 150, 150), 600);
        send("fb3", 8'd250, off4(0, 0, 0, 0), 4'hF);
        check_out("fb3", t4(255, 255, 255, 255), 1020);
`else
        send("wrap1", 8'd1, off4(0, 1, 5, 15), 4'hF);
        check_out("wrap1", t4(1, 0, 0, 0), 1);
        for (int s = 2; s <= 20; s++) begin
            send($sformatf("wrap%0d", s), 8'(s), off4(0, 1, 5, 15), 4'hF);
        end
        check_out("wrap20", t4(20, 19, 15, 5), 59);
`endif

        // in_valid held high: one accept every 7 cycles
        wait_ready("held");
        do_reset();
        in_sample  = 8'd50;
        tap_offset = off4(0, 0, 0, 0);
        tap_en     = 4'hF;
        in_valid   = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            check($sformatf("held_c%0d_out_valid", c), 32'(out_valid), (c % 7 == 0) ? 1 : 0);
            check($sformatf("held_c%0d_busy", c), 32'(busy), (c % 7 == 0) ? 0 : 1);
            check($sformatf("held_c%0d_overrun", c), 32'(overrun), (c >= 2) ? 1 : 0);
        end
        in_valid = 1'b0;
        wait_ready("held_end");
        check("held_mix_nonzero", 32'(mix_out != '0), 1);

        // reset while in READ
        in_sample  = 8'd33;
        tap_offset = off4(0, 0, 0, 0);
        tap_en     = 4'hF;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        do_reset();
        check("midrst_busy",      32'(busy), 0);
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_tap_out",   32'(tap_out), 0);
        check("midrst_mix",       32'(mix_out), 0);
        check("midrst_overrun",   32'(overrun), 0);
        begin
            int pulses = 0;
            for (int c = 0; c < 10; c++) begin
                tick();
                if (out_valid) pulses++;
            end
            check("midrst_no_pulse", pulses, 0);
        end

        // table: first entry is the first sample after the mid-READ reset
        for (int v = 0; v < 5; v++) begin
            send($sformatf("vec%0d", v), vecs[v].smp, vecs[v].off, vecs[v].en);
            check_out($sformatf("vec%0d", v), vecs[v].taps, 32'(vecs[v].mix));
        end

        // outputs hold between pulses
        tick();
        tick();
        check("hold_out_valid", 32'(out_valid), 0);
        check_out("hold", vecs[4].taps, 32'(vecs[4].mix));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
